vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised two-axis VGA timing generator. It replaces the single-axis horizontal sync block, and drives the pong game and video output path from the system clock. Horizontal and vertical counters advance on a synchronised pixel-clock tick. The block produces programmable-polarity hsync/vsync, x/y coordinates covering the full line and frame, a display-enable, and line/frame end flags. Timing segments are run-time inputs, so one instance serves multiple video modes.

## Interface
- XW, 10, width of x counter and horizontal segment inputs
- YW, 10, width of y counter and vertical segment inputs

- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-low reset
- PixelClock  in  1  pixel-rate strobe, not synchronous to CLK
- Restart  in  1  level; rising edge forces pre-frame state
- HActive, HFront, HSync, HBack  in  XW each  horizontal segment lengths in pixels
- VActive, VFront, VSync, VBack  in  YW each  vertical segment lengths in lines
- HSyncPol, VSyncPol  in  1  active level of hsync/vsync (0 = active-low, VGA default)
- hsync, vsync  out  1  sync outputs, polarity applied
- DisplayEnable  out  1  high while x < HActive and y < VActive
- xposition  out  XW  current pixel, 0..HTotal-1
- yposition  out  YW  current line, 0..VTotal-1
- LineEnd  out  1  high while x == HTotal-1
- FrameEnd  out  1  high while x == HTotal-1 and y == VTotal-1

## Operation
- HTotal = HActive+HFront+HSync+HBack, computed XW+2 bits wide. VTotal is formed the same way at YW+2 bits. Integrators guarantee HTotal ≤ 2^XW and VTotal ≤ 2^YW. Behaviour is unspecified otherwise.
- Line order: Active, FrontPorch, Sync, BackPorch. The frame uses the same order.
- Sync window:
  - hsync active iff HActive+HFront ≤ x < HActive+HFront+HSync.
  - vsync active iff VActive+VFront ≤ y < VActive+VFront+VSync.
  - A zero-length sync segment is never active.
- PixelClock path: two-flop synchroniser, then rising-edge detect gives `tick`. tick is high for one CLK per PixelClock rising edge.
- On tick, x advances:
  - If x ≥ HTotal-1, x ← 0 and y advances.
  - Otherwise x ← x+1.
  - The ≥ compare guarantees wrap if segment inputs shrink mid-line.
- On y advance:
  - If y ≥ VTotal-1, y ← 0.
  - Otherwise y ← y+1.
- Pre-frame state: x = HTotal-1, y = VTotal-1, using the segment inputs sampled that cycle. The next tick wraps to (0,0), so pixel (0,0) of the first frame is never lost.
- Restart: a two-flop sync plus rising-edge detect yields a one-CLK pulse. On that pulse the counters load the pre-frame state.
- Precedence, highest first: RESET low, then Restart pulse, then tick. A tick coincident with a Restart pulse is dropped.
- All outputs are registered and decoded from the next-state counter values, so flags and coordinates change on the same CLK edge.
- Reset mid-frame abandons the frame immediately. No partial sync pulse is stretched.

## Timing
- Reset values (RESET low at a CLK edge):
  - xposition = HTotal-1, yposition = VTotal-1
  - LineEnd = 1, FrameEnd = 1, DisplayEnable = 0
  - hsync = ~HSyncPol, vsync = ~VSyncPol. This assumes non-degenerate porches, where the pre-frame position lies in the back porch.
- PixelClock rising edge to tick: 2–3 CLK, depending on sampling phase.
- tick to updated outputs: 1 CLK, on the edge following tick.
- Restart rising edge to pre-frame outputs: 3–4 CLK.
- PixelClock must be high ≥ 2 CLK and low ≥ 2 CLK. Faster strobes are undefined.
- Segment inputs are sampled combinationally each cycle. Changes take effect on the next tick or reset/Restart.

## Configuration
- VGA_FRAME_COUNT_EN defined:
  - Adds output FrameCount, out, 8 bits.
  - Increments, wrapping 255→0, on every tick that moves (x,y) from (HTotal-1, VTotal-1) to (0,0).
  - Reset clears it to 0. Restart does not alter it.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Small mode: HActive=4, HFront=1, HSync=2, HBack=1 (HTotal 8); VActive=3, VFront=1, VSync=1, VBack=1 (VTotal 6); polarities 0; 48 ticks.
  - x runs 0..7 and y runs 0..5, starting from (0,0).
  - hsync low exactly at x=5,6.
  - vsync low exactly for y=4.
  - DisplayEnable high for x<4 and y<3 (12 ticks per frame).
  - LineEnd high at x=7. FrameEnd high at (7,5).
- Reset: hold RESET low mid-frame with the small mode.
  - Outputs equal (7,5), LineEnd=1, FrameEnd=1, DisplayEnable=0, hsync=1, vsync=1.
  - First tick after release gives (0,0) with DisplayEnable=1.
- Restart coincident with tick at (2,1):
  - Tick dropped; counters go to (7,5).
  - Next tick gives (0,0). FrameCount (if VGA_FRAME_COUNT_EN) unchanged.
- Mode shrink: at x=7, change HActive to 2 (HTotal 6).
  - Next tick wraps to x=0 and y increments.
  - Subsequent lines wrap at x=5.
- 640×480 settings, HSyncPol=VSyncPol=0: 640/16/96/48 and 480/10/2/33.
  - hsync low for x=656..751.
  - vsync low for y=490..491.
  - 800×525 ticks per frame.
  - With VGA_FRAME_COUNT_EN: FrameCount goes 0→1 at the first (799,524)→(0,0) wrap.
- HSync=0, HSyncPol=1: hsync stays 0 for a full line. LineEnd timing is unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-axis VGA timing generator.
// Horizontal and vertical counters advance on a synchronised pixel-clock tick.
// The segment lengths are run-time inputs. Sync polarity is programmable.
// Optional feature: define VGA_FRAME_COUNT_EN to add an 8-bit FrameCount output.
module vga_timing_gen #(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PixelClock,
  input  logic          Restart,
  input  logic [XW-1:0] HActive,
  input  logic [XW-1:0] HFront,
  input  logic [XW-1:0] HSync,
  input  logic [XW-1:0] HBack,
  input  logic [YW-1:0] VActive,
  input  logic [YW-1:0] VFront,
  input  logic [YW-1:0] VSync,
  input  logic [YW-1:0] VBack,
  input  logic          HSyncPol,
  input  logic          VSyncPol,
  output logic          hsync,
  output logic          vsync,
  output logic          DisplayEnable,
  output logic [XW-1:0] xposition,
  output logic [YW-1:0] yposition,
  output logic          LineEnd,
  output logic          FrameEnd
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]    FrameCount
`endif
);

  // Segment sums are two bits wider than the counters so that they cannot overflow.
  localparam int HW = XW + 2;
  localparam int VW = YW + 2;

  logic [HW-1:0] h_total, h_last, hs_start, hs_end;
  logic [VW-1:0] v_total, v_last, vs_start, vs_end;

  logic [1:0]    pix_sync_q, pix_sync_d;
  logic          pix_prev_q, pix_prev_d;
  logic [1:0]    rst_sync_q, rst_sync_d;
  logic          rst_prev_q, rst_prev_d;
  logic          tick, restart_pulse;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_wrap, y_wrap;
  logic [HW-1:0] x_ext;
  logic [VW-1:0] y_ext;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          le_q, le_d;
  logic          fe_q, fe_d;

  // Segment boundaries derived from the current inputs.
  always_comb begin
    h_total  = {2'b00, HActive} + {2'b00, HFront} + {2'b00, HSync} + {2'b00, HBack};
    h_last   = h_total - HW'(1);
    hs_start = {2'b00, HActive} + {2'b00, HFront};
    hs_end   = hs_start + {2'b00, HSync};
    v_total  = {2'b00, VActive} + {2'b00, VFront} + {2'b00, VSync} + {2'b00, VBack};
    v_last   = v_total - VW'(1);
    vs_start = {2'b00, VActive} + {2'b00, VFront};
    vs_end   = vs_start + {2'b00, VSync};
  end

  // Synchronise the pixel strobe and Restart, then detect rising edges on both.
  always_comb begin
    pix_sync_d    = {pix_sync_q[0], PixelClock};
    pix_prev_d    = pix_sync_q[1];
    rst_sync_d    = {rst_sync_q[0], Restart};
    rst_prev_d    = rst_sync_q[1];
    tick          = pix_sync_q[1] & ~pix_prev_q;
    restart_pulse = rst_sync_q[1] & ~rst_prev_q;
  end

  // Counter next state. Reset and Restart load the pre-frame position.
  // The >= compares make the counters wrap when the segments shrink.
  always_comb begin
    x_wrap = ({2'b00, x_q} >= h_last);
    y_wrap = ({2'b00, y_q} >= v_last);
    x_d    = x_q;
    y_d    = y_q;
    if (!RESET || restart_pulse) begin
      x_d = h_last[XW-1:0];
      y_d = v_last[YW-1:0];
    end else if (tick) begin
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) y_d = '0;
        else        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Decode the outputs from the next-state position so that flags and coordinates change on the same edge.
  always_comb begin
    x_ext   = {2'b00, x_d};
    y_ext   = {2'b00, y_d};
    de_d    = (x_ext < {2'b00, HActive}) && (y_ext < {2'b00, VActive});
    hsync_d = ((x_ext >= hs_start) && (x_ext < hs_end)) ? HSyncPol : ~HSyncPol;
    vsync_d = ((y_ext >= vs_start) && (y_ext < vs_end)) ? VSyncPol : ~VSyncPol;
    le_d    = (x_ext == h_last);
    fe_d    = le_d && (y_ext == v_last);
  end

  // Synchroniser flops are cleared by reset. The counter and output flops already take the reset value from their _d logic.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pix_sync_q <= '0;
      pix_prev_q <= 1'b0;
      rst_sync_q <= '0;
      rst_prev_q <= 1'b0;
    end else begin
      pix_sync_q <= pix_sync_d;
      pix_prev_q <= pix_prev_d;
      rst_sync_q <= rst_sync_d;
      rst_prev_q <= rst_prev_d;
    end
    x_q     <= x_d;
    y_q     <= y_d;
    hsync_q <= hsync_d;
    vsync_q <= vsync_d;
    de_q    <= de_d;
    le_q    <= le_d;
    fe_q    <= fe_d;
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Count every tick that wraps both axes. Restart drops the tick, so it does not count.
  always_comb begin
    frame_cnt_d = frame_cnt_q + 8'((tick && !restart_pulse && x_wrap && y_wrap) ? 1 : 0);
  end

  // The frame counter is cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!RESET) frame_cnt_q <= 8'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign FrameCount = frame_cnt_q;
`else
  // No frame counter in this build.
`endif

  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign DisplayEnable = de_q;
  assign xposition     = x_q;
  assign yposition     = y_q;
  assign LineEnd       = le_q;
  assign FrameEnd      = fe_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen: small mode, reset, Restart, mode shrink,
// zero-length sync, and the 640x480 sync windows.
module tb_vga_timing_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] ha, hf, hs_len, hb;
  logic [9:0] va, vf, vs_len, vb;
  logic       hpol = 1'b0, vpol = 1'b0;
  logic       hs, vs, de, le, fe;
  logic [9:0] xp, yp;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen #(.XW(10), .YW(10)) dut (
    .CLK(clk), .RESET(rst_n), .PixelClock(pix), .Restart(restart),
    .HActive(ha), .HFront(hf), .HSync(hs_len), .HBack(hb),
    .VActive(va), .VFront(vf), .VSync(vs_len), .VBack(vb),
    .HSyncPol(hpol), .VSyncPol(vpol),
    .hsync(hs), .vsync(vs), .DisplayEnable(de),
    .xposition(xp), .yposition(yp), .LineEnd(le), .FrameEnd(fe)
`ifdef VGA_FRAME_COUNT_EN
    , .FrameCount(fc)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One PixelClock period: high 2 CLK, low 2 CLK. Call at a negedge. Outputs are settled on return.
  task automatic pix_tick();
    pix = 1'b1;
    repeat (2) @(negedge clk);
    pix = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_mode(input int a, f, s, b, input int c, g, t, d);
    ha = 10'(a); hf = 10'(f); hs_len = 10'(s); hb = 10'(b);
    va = 10'(c); vf = 10'(g); vs_len = 10'(t); vb = 10'(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    set_mode(4, 1, 2, 1, 3, 1, 1, 1);
    @(negedge clk);
    do_reset();
    // Reset state: pre-frame (7,5) in the back porch.
    check_val("rst_x", xp, 7);
    check_val("rst_y", yp, 5);
    check_val("rst_le", le, 1);
    check_val("rst_fe", fe, 1);
    check_val("rst_de", de, 0);
    check_val("rst_hs", hs, 1);
    check_val("rst_vs", vs, 1);
`ifdef VGA_FRAME_COUNT_EN
    check_val("rst_fc", fc, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Small mode: 48 ticks cover one full 8x6 frame.
    for (int i = 0; i < 48; i++) begin
      int ex, ey;
      ex = i % 8;
      ey = (i / 8) % 6;
      pix_tick();
      $display("small tick %0d: x=%0d y=%0d hs=%0d vs=%0d de=%0d", i, xp, yp, hs, vs, de);
      check_val("small_x", xp, ex);
      check_val("small_y", yp, ey);
      check_val("small_hs", hs, (ex == 5 || ex == 6) ? 0 : 1);
      check_val("small_vs", vs, (ey == 4) ? 0 : 1);
      check_val("small_de", de, (ex < 4 && ey < 3) ? 1 : 0);
      check_val("small_le", le, (ex == 7) ? 1 : 0);
      check_val("small_fe", fe, (ex == 7 && ey == 5) ? 1 : 0);
    end
`ifdef VGA_FRAME_COUNT_EN
    check_val("small_fc", fc, 1);
`endif

    // Mid-frame reset at (2,1).
    repeat (11) pix_tick();
    check_val("mid_x", xp, 2);
    check_val("mid_y", yp, 1);
    do_reset();
    check_val("mrst_x", xp, 7);
    check_val("mrst_y", yp, 5);
    check_val("mrst_de", de, 0);
    check_val("mrst_hs", hs, 1);
    check_val("mrst_vs", vs, 1);
    rst_n = 1'b1;
    @(negedge clk);
    pix_tick();
    $display("after reset: x=%0d y=%0d de=%0d", xp, yp, de);
    check_val("arst_x", xp, 0);
    check_val("arst_y", yp, 0);
    check_val("arst_de", de, 1);
`ifdef VGA_FRAME_COUNT_EN
    check_val("arst_fc", fc, 1);
`endif

    // Restart coincident with a tick at (2,1). The tick is dropped.
    repeat (10) pix_tick();
    check_val("pre_rs_x", xp, 2);
    check_val("pre_rs_y", yp, 1);
    restart = 1'b1;
    pix_tick();
    $display("restart: x=%0d y=%0d le=%0d fe=%0d", xp, yp, le, fe);
    check_val("rs_x", xp, 7);
    check_val("rs_y", yp, 5);
    check_val("rs_fe", fe, 1);
`ifdef VGA_FRAME_COUNT_EN
    check_val("rs_fc", fc, 1);
`endif
    restart = 1'b0;
    repeat (2) @(negedge clk);
    pix_tick();
    check_val("post_rs_x", xp, 0);
    check_val("post_rs_y", yp, 0);

    // Mode shrink at x=7: HActive drops to 2 (HTotal 6, hsync at x=3,4).
    repeat (7) pix_tick();
    check_val("shr_x7", xp, 7);
    ha = 10'd2;
    pix_tick();
    $display("shrink wrap: x=%0d y=%0d", xp, yp);
    check_val("shr_x", xp, 0);
    check_val("shr_y", yp, 1);
    check_val("shr_de", de, 1);
    for (int k = 1; k < 6; k++) begin
      pix_tick();
      check_val("shr_line_x", xp, k);
      check_val("shr_line_le", le, (k == 5) ? 1 : 0);
      check_val("shr_line_hs", hs, (k == 3 || k == 4) ? 0 : 1);
    end
    pix_tick();
    check_val("shr_wrap_x", xp, 0);
    check_val("shr_wrap_y", yp, 2);

    // Zero-length hsync with active-high polarity: hsync stays 0 for the whole line.
    set_mode(4, 1, 0, 3, 3, 1, 1, 1);
    hpol = 1'b1;
    do_reset();
    check_val("hz_rst_hs", hs, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      pix_tick();
      check_val("hz_x", xp, k);
      check_val("hz_hs", hs, 0);
      check_val("hz_le", le, (k == 7) ? 1 : 0);
    end
    hpol = 1'b0;

    // 640x480: one full line checks the horizontal windows.
    set_mode(640, 16, 96, 48, 480, 10, 2, 33);
    do_reset();
    check_val("v640_rst_x", xp, 799);
    check_val("v640_rst_y", yp, 524);
    check_val("v640_rst_hs", hs, 1);
    check_val("v640_rst_vs", vs, 1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 800; k++) begin
      pix_tick();
      check_val("v640_x", xp, k);
      check_val("v640_hs", hs, (k >= 656 && k <= 751) ? 0 : 1);
      check_val("v640_de", de, (k < 640) ? 1 : 0);
      check_val("v640_le", le, (k == 799) ? 1 : 0);
    end
    $display("640 line done: x=%0d y=%0d", xp, yp);
`ifdef VGA_FRAME_COUNT_EN
    check_val("v640_fc", fc, 1);
`endif

    // Vertical windows: a one-pixel line walks through all 525 lines quickly.
    set_mode(1, 0, 0, 0, 480, 10, 2, 33);
    restart = 1'b1;
    repeat (4) @(negedge clk);
    restart = 1'b0;
    repeat (2) @(negedge clk);
    check_val("vert_rs_x", xp, 0);
    check_val("vert_rs_y", yp, 524);
    for (int k = 0; k < 525; k++) begin
      pix_tick();
      check_val("vert_y", yp, k);
      check_val("vert_vs", vs, (k == 490 || k == 491) ? 0 : 1);
      check_val("vert_fe", fe, (k == 524) ? 1 : 0);
    end
    pix_tick();
    check_val("vert_wrap_y", yp, 0);
`ifdef VGA_FRAME_COUNT_EN
    check_val("vert_fc", fc, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
